// File: rtl/led_pattern_if.sv
// Light-vector bus between the pattern generator and its receive-side monitor.
// The master drives the light vector and control inputs; the slave returns the decoded status.
interface led_pattern_if #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
);
  logic [7:0]       din;
  logic             din_valid;
  logic             clr_err;
  logic [2:0]       pos;
  logic             pos_valid;
  logic             all_on;
  logic             step_pulse;
  logic [LAP_W-1:0] lap_count;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output din, din_valid, clr_err,
    input  pos, pos_valid, all_on, step_pulse, lap_count, err_pulse, err_count
  );

  modport slave (
    input  din, din_valid, clr_err,
    output pos, pos_valid, all_on, step_pulse, lap_count, err_pulse, err_count
  );
endinterface

// File: rtl/led_pattern_monitor.sv
// Checks the walking-light pattern (FF, 01, 02 .. 80, 01 ..) and reports position, laps and errors.
// All outputs are registered and reflect the sample taken on the previous rising edge.
module led_pattern_monitor #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  led_pattern_if.slave  bus
);

  typedef enum logic [1:0] {S_WAIT, S_ALLON, S_WALK, S_ERROR} state_t;

  state_t           state_q, state_d, eval_state;
  logic [7:0]       prev_q, prev_d;
  logic [2:0]       pos_q, pos_d;
  logic             pos_valid_q, all_on_q;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             lap_inc;
  logic [LAP_W-1:0] lap_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [7:0]       prev_rotl;
  logic             clr_from_err;

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign prev_rotl    = {prev_q[6:0], prev_q[7]};
  assign clr_from_err = bus.clr_err && (state_q == S_ERROR);

  always_comb begin
    // A clear out of ERROR makes the same-cycle sample look as if it arrived in WAIT.
    eval_state = clr_from_err ? S_WAIT : state_q;
    state_d    = eval_state;
    prev_d     = prev_q;
    pos_d      = pos_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    lap_inc    = 1'b0;
    if (bus.din_valid) begin
      unique case (eval_state)
        S_WAIT, S_ERROR: begin
          if (bus.din == 8'hFF) begin
            state_d = S_ALLON;
            prev_d  = bus.din;
          end
        end
        S_ALLON: begin
          prev_d = bus.din;
          if (bus.din == 8'h01) begin
            state_d = S_WALK;
            pos_d   = 3'd0;
            step_d  = 1'b1;
          end else if (bus.din != 8'hFF) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        S_WALK: begin
          prev_d = bus.din;
          if (bus.din == prev_q) begin
            state_d = S_WALK;
          end else if (bus.din == prev_rotl) begin
            pos_d   = onehot_idx(bus.din);
            step_d  = 1'b1;
            lap_inc = (prev_q == 8'h80);
          end else if (bus.din == 8'hFF) begin
            state_d = S_ALLON;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT;
      prev_q      <= 8'h00;
      pos_q       <= 3'd0;
      pos_valid_q <= 1'b0;
      all_on_q    <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      lap_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pos_q       <= pos_d;
      pos_valid_q <= (state_d == S_WALK);
      all_on_q    <= (state_d == S_ALLON);
      step_q      <= step_d;
      err_q       <= err_d;
      if (lap_inc) lap_q <= lap_q + 1'b1;
      if (bus.clr_err) begin
        err_cnt_q <= '0;
      end else if (err_d && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.pos        = pos_q;
  assign bus.pos_valid  = pos_valid_q;
  assign bus.all_on     = all_on_q;
  assign bus.step_pulse = step_q;
  assign bus.lap_count  = lap_q;
  assign bus.err_pulse  = err_q;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: doc/led_pattern_monitor.md
Name: led_pattern_monitor

Overview:
- Receive-side checker for the 8-light walking pattern bus driven by the light generator.
- Samples the 8-bit light vector on a valid strobe and tracks the pattern state machine.
- Outputs the lit position, counts completed laps, and flags illegal pattern transitions.
- Sits beside the light generator on the board top, either as a self-check monitor or to feed a 7-segment position display.

Parameters:
- LAP_W, 8, width of the lap counter; wraps modulo 2^LAP_W.
- ERR_W, 4, width of the error counter; saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  8  light vector from the generator.
- din_valid  input  1  din is sampled on a rising edge only when this is high.
- clr_err  input  1  synchronous clear of err_count and the ERROR state.
- pos  output  3  binary index of the lit light while walking.
- pos_valid  output  1  high while state = WALK.
- all_on  output  1  high while state = ALLON.
- step_pulse  output  1  one-cycle pulse on each legal advance of the lit light.
- lap_count  output  LAP_W  number of 8'h80 -> 8'h01 transitions seen.
- err_pulse  output  1  one-cycle pulse on each illegal transition.
- err_count  output  ERR_W  saturating count of illegal transitions.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - state = WAIT.
  - pos = 0, pos_valid = 0, all_on = 0.
  - step_pulse = 0, err_pulse = 0.
  - lap_count = 0, err_count = 0.
  - Internal prev register = 8'h00.
- Timing:
  - All outputs are registered.
  - Effect of a sample at edge N is visible after edge N (1-cycle latency).
- din_valid low:
  - State, prev, pos, lap_count and err_count all hold.
  - step_pulse and err_pulse are 0.
- Pattern protocol, legal din values:
  - 8'hFF (all on).
  - One-hot values; the sequence is FF -> 01 -> 02 -> ... -> 80 -> 01 (rotate-left).
  - Repeating the same value is a legal hold.
- States and transitions (evaluated only when din_valid = 1):
  - WAIT: din = FF -> ALLON. Any other value is ignored: no error, stays in WAIT.
  - ALLON:
    - FF -> hold in ALLON.
    - 01 -> WALK with pos = 0 and step_pulse.
    - Anything else -> ERROR with err_pulse.
  - WALK (prev is one-hot p):
    - din = p -> hold, no pulse.
    - din = rotl(p) -> stay in WALK, pos = index(din), step_pulse.
    - din = FF -> ALLON (legal restart, no error).
    - Anything else, including 00, multi-bit or backward step -> ERROR with err_pulse.
  - ERROR: only din = FF -> ALLON. All other values are ignored, with no further err_pulse.
- Lap counting:
  - lap_count increments on WALK with prev = 80 and din = 01.
  - Wraps from 2^LAP_W-1 to 0.
- err_count:
  - Increments with each err_pulse.
  - Saturates at all-ones; err_pulse still fires when saturated.
- pos:
  - Updated only on entering or advancing in WALK.
  - Holds its last value in other states; qualify with pos_valid.
- prev:
  - Updated with din on every valid sample, in every state.
  - Exception: in WAIT and ERROR it updates only when din = FF.
- clr_err:
  - Zeroes err_count.
  - If state = ERROR, moves it to WAIT.
  - Takes priority over a same-cycle illegal sample: that sample is evaluated from WAIT, so it causes no err_pulse.
- reset has priority over everything. reset mid-walk returns to WAIT and clears both counters.

Test Plan:
- Reset, then valid samples FF, 01, 02, 04, 08, 10, 20, 40, 80, 01 -> all_on after FF; pos 0..7 then 0; 9 step_pulses; lap_count = 1; err_count = 0.
- WAIT, then samples 04, 3C, FF -> no err_pulse while in WAIT; all_on = 1 one cycle after the FF sample.
- In WALK at pos 2 (din 04), sample 04 x3 then din_valid low for 5 cycles -> pos stays 2, no step_pulse, state unchanged.
- In WALK at 08, sample 20 -> err_pulse one cycle, err_count = 1, pos_valid = 0. Then 40 -> no pulse. Then FF -> all_on = 1.
- Force 16 illegal transitions (each recovered via FF, 01, 03) with ERR_W = 4 -> err_count stops at 15 while err_pulse still fires. Then clr_err -> err_count = 0.
- In WALK at 80 with lap_count = 255 (LAP_W = 8), sample 01 -> lap_count = 0. Then assert reset during WALK -> all outputs 0 the next cycle and state = WAIT.
